// File: rtl/demux_32b_1x2_buffered_pkg.sv
// Shared constants and helpers for the buffered 1-to-2 word demultiplexer.
package demux_32b_1x2_buffered_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic DEST_0 = 1'b0;
    localparam logic DEST_1 = 1'b1;

    // Ceiling log2, used to size FIFO pointers.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_32b_1x2_buffered_fifo.sv
// Single-clock FIFO with a registered head word that holds its last value when empty.
module demux_fifo
    import demux_32b_1x2_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        head_d   = head_q;
        // The pushed word becomes the head when the post-edge read pointer lands on its slot.
        if (push_i && (rd_ptr_d == wr_ptr_q)) begin
            head_d = wdata_i;
        end else if (pop_i && (count_d != '0)) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = head_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/demux_32b_1x2_buffered.sv
// 1-to-2 word demultiplexer with an independent FIFO per destination.
module demux_32b_1x2_buffered
    import demux_32b_1x2_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [AW:0]      out0_count,
    output logic [AW:0]      out1_count
);

    logic full0, full1;
    logic empty0, empty1;
    logic accept;
    logic push0, push1;
    logic pop0, pop1;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign in_ready = (in_sel == DEST_1) ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (in_sel == DEST_0);
    assign push1    = accept & (in_sel == DEST_1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push0),
        .wdata_i (in_data),
        .pop_i   (pop0),
        .rdata_o (out0_data),
        .full_o  (full0),
        .empty_o (empty0),
        .count_o (out0_count)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push1),
        .wdata_i (in_data),
        .pop_i   (pop1),
        .rdata_o (out1_data),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (out1_count)
    );

endmodule

// File: tb/tb_demux_32b_1x2_buffered.sv
// Randomized and directed bench for the buffered 1-to-2 demultiplexer, checked against queue models.
module tb_demux_32b_1x2_buffered;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [1:0]  out0_count;
    logic [1:0]  out1_count;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last0, last1;
    logic [31:0] got0[$];
    logic [31:0] got1[$];
    int unsigned sent0, sent1;
    bit          last_acc;

    demux_32b_1x2_buffered #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp0, exp1;
        exp0 = last0;
        exp1 = last1;
        if (q0.size() != 0) exp0 = q0[0];
        if (q1.size() != 0) exp1 = q1[0];
        check({tag, ".v0"}, 32'(out0_valid), 32'(q0.size() != 0));
        check({tag, ".v1"}, 32'(out1_valid), 32'(q1.size() != 0));
        check({tag, ".c0"}, 32'(out0_count), q0.size());
        check({tag, ".c1"}, 32'(out1_count), q1.size());
        check({tag, ".d0"}, out0_data, exp0);
        check({tag, ".d1"}, out1_data, exp1);
        check({tag, ".rdy"}, 32'(in_ready), 32'(in_sel ? (q1.size() < 2) : (q0.size() < 2)));
    endtask

    // Inputs are set at a negedge before calling; returns at the following negedge.
    task automatic tick(input string tag);
        bit acc, p0, p1;
        #1;
        check_outputs(tag);
        acc = in_valid && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
        p0  = (q0.size() != 0) && out0_ready;
        p1  = (q1.size() != 0) && out1_ready;
        if (out0_valid && out0_ready) got0.push_back(out0_data);
        if (out1_valid && out1_ready) got1.push_back(out1_data);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (in_sel) begin
                q1.push_back(in_data);
                sent1++;
            end else begin
                q0.push_back(in_data);
                sent0++;
            end
        end
        if (q0.size() != 0) last0 = q0[0];
        if (q1.size() != 0) last1 = q1[0];
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        int unsigned accepted, cycles;
        n_checks = 0;
        n_errors = 0;
        sent0 = 0;
        sent1 = 0;
        last_acc = 1'b0;
        rst = 1'b1;
        offer(1'b0, 1'b0, '0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Routing with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        offer(1'b1, 1'b0, 32'hDEADBEEF);
        tick("route_a");
        check("route0_valid", 32'(out0_valid), 32'd1);
        check("route0_data", out0_data, 32'hDEADBEEF);
        offer(1'b1, 1'b1, 32'h12345678);
        tick("route_b");
        check("route0_pulse", 32'(out0_valid), 32'd0);
        check("route1_valid", 32'(out1_valid), 32'd1);
        check("route1_data", out1_data, 32'h12345678);
        offer(1'b0, 1'b0, '0);
        tick("route_c");
        check("route1_pulse", 32'(out1_valid), 32'd0);
        check("route0_hold", out0_data, 32'hDEADBEEF);

        // Backpressure on destination 0.
        out0_ready = 1'b0;
        offer(1'b1, 1'b0, 32'h1);
        tick("bp_1");
        offer(1'b1, 1'b0, 32'h2);
        tick("bp_2");
        check("bp_cnt0", 32'(out0_count), 32'd2);
        offer(1'b0, 1'b0, '0);
        #1 check("bp_rdy_sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1 check("bp_rdy_sel1", 32'(in_ready), 32'd1);
        offer(1'b1, 1'b1, 32'hA);
        tick("bp_a");
        check("bp_a_valid", 32'(out1_valid), 32'd1);
        check("bp_a_data", out1_data, 32'hA);
        check("bp_a_cnt0", 32'(out0_count), 32'd2);

        // Full plus pop: 0x3 waits one cycle even though a slot frees up.
        got0.delete();
        offer(1'b1, 1'b0, 32'h3);
        tick("fp_stall");
        out0_ready = 1'b1;
        tick("fp_pop");
        check("fp_not_acc", 32'(out0_count), 32'd1);
        out0_ready = 1'b0;
        tick("fp_push");
        check("fp_acc", 32'(out0_count), 32'd2);
        offer(1'b0, 1'b0, '0);
        out0_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick("fp_drain");
        check("fp_n", got0.size(), 32'd3);
        if (got0.size() == 3) begin
            check("fp_ord0", got0[0], 32'h1);
            check("fp_ord1", got0[1], 32'h2);
            check("fp_ord2", got0[2], 32'h3);
        end

        // Reset mid-stream with FIFO 0 holding two words.
        out0_ready = 1'b0;
        offer(1'b1, 1'b0, 32'h55);
        tick("rs_1");
        offer(1'b1, 1'b0, 32'h66);
        tick("rs_2");
        check("rs_pre_cnt0", 32'(out0_count), 32'd2);
        offer(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rs_v0", 32'(out0_valid), 32'd0);
        check("rs_c0", 32'(out0_count), 32'd0);
        check("rs_c1", 32'(out1_count), 32'd0);
        check("rs_d0", out0_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rs_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Random traffic with the producer holding an unaccepted offer.
        got0.delete();
        got1.delete();
        sent0 = 0;
        sent1 = 0;
        accepted = 0;
        cycles = 0;
        last_acc = 1'b1;
        while (accepted < 100 && cycles < 3000) begin
            if (!(in_valid && !last_acc)) begin
                offer($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom);
            end
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            tick("rnd");
            if (last_acc) accepted++;
            cycles++;
        end
        check("rnd_accepted", accepted, 32'd100);
        offer(1'b0, 1'b0, '0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("rnd_drain");
        check("rnd_end_c0", 32'(out0_count), 32'd0);
        check("rnd_end_c1", 32'(out1_count), 32'd0);
        check("rnd_n0", got0.size(), sent0);
        check("rnd_n1", got1.size(), sent1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
